// File: rtl/ex_mem_pipeline_reg_pkg.sv
// rtl/ex_mem_pipeline_reg_pkg.sv - shared EX/MEM pipeline constants and occupancy encoding
package ex_mem_pipeline_reg_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int RADDR_W_DEF = 4;
  localparam int CNT_W_DEF   = 8;
  localparam int CTRL_W      = 4;

  localparam int CTRL_MEM_RD  = 0;
  localparam int CTRL_MEM_WR  = 1;
  localparam int CTRL_REG_WR  = 2;
  localparam int CTRL_PAIR_WR = 3;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/ex_mem_pipeline_reg_if.sv
// rtl/ex_mem_pipeline_reg_if.sv - valid/ready beat channel carrying one EX/MEM payload
interface ex_mem_pipeline_reg_if
  import ex_mem_pipeline_reg_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF
);

  logic                valid;
  logic                ready;
  logic [DATA_W-1:0]   data_top;
  logic [DATA_W-1:0]   data_bot;
  logic [RADDR_W-1:0]  rd;
  logic [CTRL_W-1:0]   ctrl;

  modport master (output valid, data_top, data_bot, rd, ctrl, input ready);
  modport slave  (input valid, data_top, data_bot, rd, ctrl, output ready);

endinterface

// File: rtl/ex_mem_pipeline_reg_entry.sv
// rtl/ex_mem_pipeline_reg_entry.sv - enable-loaded payload register for one buffer entry
module pipe_payload_entry
  import ex_mem_pipeline_reg_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [DATA_W-1:0]  top_i,
  input  logic [DATA_W-1:0]  bot_i,
  input  logic [RADDR_W-1:0] rd_i,
  input  logic [CTRL_W-1:0]  ctrl_i,
  output logic [DATA_W-1:0]  top_o,
  output logic [DATA_W-1:0]  bot_o,
  output logic [RADDR_W-1:0] rd_o,
  output logic [CTRL_W-1:0]  ctrl_o
);

  logic [DATA_W-1:0]  top_q;
  logic [DATA_W-1:0]  bot_q;
  logic [RADDR_W-1:0] rd_q;
  logic [CTRL_W-1:0]  ctrl_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      top_q  <= '0;
      bot_q  <= '0;
      rd_q   <= '0;
      ctrl_q <= '0;
    end else if (load_i) begin
      top_q  <= top_i;
      bot_q  <= bot_i;
      rd_q   <= rd_i;
      ctrl_q <= ctrl_i;
    end
  end

  assign top_o  = top_q;
  assign bot_o  = bot_q;
  assign rd_o   = rd_q;
  assign ctrl_o = ctrl_q;

endmodule

// File: rtl/ex_mem_pipeline_reg.sv
// rtl/ex_mem_pipeline_reg.sv - EX/MEM two-entry skid buffer with forwarding taps and stall counter
module ex_mem_pipeline_reg
  import ex_mem_pipeline_reg_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    flush,
  ex_mem_pipeline_reg_if.slave    ex,
  ex_mem_pipeline_reg_if.master   mem,
  output logic                    fwd_valid,
  output logic [RADDR_W-1:0]      fwd_rd,
  output logic [2*DATA_W-1:0]     fwd_data,
  output logic [CNT_W-1:0]        stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  occ_e               state_q, state_d;
  logic               ex_ready_q, ex_ready_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic               accept, pop, mem_valid;
  logic               head_load, head_from_skid, skid_load;

  logic [DATA_W-1:0]  head_top, head_bot, skid_top, skid_bot;
  logic [RADDR_W-1:0] head_rd, skid_rd;
  logic [CTRL_W-1:0]  head_ctrl, skid_ctrl;
  logic [DATA_W-1:0]  hsrc_top, hsrc_bot;
  logic [RADDR_W-1:0] hsrc_rd;
  logic [CTRL_W-1:0]  hsrc_ctrl;

  assign mem_valid = (state_q != OCC_EMPTY);
  assign accept    = ex.valid & ex_ready_q;
  assign pop       = mem_valid & mem.ready;

  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      unique case (state_q)
        OCC_EMPTY: if (accept) begin
          head_load = 1'b1;
          state_d   = OCC_ONE;
        end
        OCC_ONE: begin
          if (accept && pop) begin
            head_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = OCC_FULL;
          end else if (pop) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_FULL: if (pop) begin
          head_load      = 1'b1;
          head_from_skid = 1'b1;
          state_d        = OCC_ONE;
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
    // Ready is a pure function of the next occupancy, so MEM ready never reaches EX combinationally.
    ex_ready_d = (state_d != OCC_FULL);
  end

  always_comb begin
    stall_d = stall_q;
    if (mem_valid && !mem.ready && !flush && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= OCC_EMPTY;
      ex_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      ex_ready_q <= ex_ready_d;
      stall_q    <= stall_d;
    end
  end

  assign hsrc_top  = head_from_skid ? skid_top  : ex.data_top;
  assign hsrc_bot  = head_from_skid ? skid_bot  : ex.data_bot;
  assign hsrc_rd   = head_from_skid ? skid_rd   : ex.rd;
  assign hsrc_ctrl = head_from_skid ? skid_ctrl : ex.ctrl;

  pipe_payload_entry #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_head (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .load_i (head_load),
    .top_i  (hsrc_top),
    .bot_i  (hsrc_bot),
    .rd_i   (hsrc_rd),
    .ctrl_i (hsrc_ctrl),
    .top_o  (head_top),
    .bot_o  (head_bot),
    .rd_o   (head_rd),
    .ctrl_o (head_ctrl)
  );

  pipe_payload_entry #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_skid (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .load_i (skid_load),
    .top_i  (ex.data_top),
    .bot_i  (ex.data_bot),
    .rd_i   (ex.rd),
    .ctrl_i (ex.ctrl),
    .top_o  (skid_top),
    .bot_o  (skid_bot),
    .rd_o   (skid_rd),
    .ctrl_o (skid_ctrl)
  );

  assign ex.ready     = ex_ready_q;
  assign mem.valid    = mem_valid;
  assign mem.data_top = head_top;
  assign mem.data_bot = head_bot;
  assign mem.rd       = head_rd;
  assign mem.ctrl     = head_ctrl;

  assign fwd_valid    = mem_valid & head_ctrl[CTRL_REG_WR];
  assign fwd_rd       = head_rd;
  assign fwd_data     = {head_top, head_bot};
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_ex_mem_pipeline_reg.sv
// tb/tb_ex_mem_pipeline_reg.sv - self-checking bench for the EX/MEM skid buffer
module tb_ex_mem_pipeline_reg;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        fwd_valid;
  logic [3:0]  fwd_rd;
  logic [15:0] fwd_data;
  logic [7:0]  stall_cycles;

  ex_mem_pipeline_reg_if #(.DATA_W(8), .RADDR_W(4)) ex_if ();
  ex_mem_pipeline_reg_if #(.DATA_W(8), .RADDR_W(4)) mem_if ();

  ex_mem_pipeline_reg #(.DATA_W(8), .RADDR_W(4), .CNT_W(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .ex           (ex_if),
    .mem          (mem_if),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
    .stall_cycles (stall_cycles)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: a bounded FIFO of {ctrl, rd, top, bot} beats, capacity 2.
  logic [23:0] m_q[$];
  logic [23:0] out_q[$];
  logic        m_rdy;
  int          m_cnt;
  logic        last_acc;

  function automatic logic [23:0] ex_beat();
    return {ex_if.ctrl, ex_if.rd, ex_if.data_top, ex_if.data_bot};
  endfunction

  function automatic logic [23:0] mem_beat();
    return {mem_if.ctrl, mem_if.rd, mem_if.data_top, mem_if.data_bot};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_rdy = 1'b1;
    m_cnt = 0;
  endtask

  task automatic drive(input logic v, input logic [7:0] t, input logic [7:0] b,
                       input logic [3:0] r, input logic [3:0] c);
    ex_if.valid = v; ex_if.data_top = t; ex_if.data_bot = b; ex_if.rd = r; ex_if.ctrl = c;
  endtask

  task automatic tick();
    logic acc, pp;
    @(posedge clock);
    acc = ex_if.valid && m_rdy && !flush;
    last_acc = acc;
    if (flush) begin
      m_q.delete();
      m_rdy = 1'b1;
    end else begin
      pp = (m_q.size() > 0) && mem_if.ready;
      if ((m_q.size() > 0) && !mem_if.ready && m_cnt < 255) m_cnt++;
      if (pp) out_q.push_back(m_q.pop_front());
      if (acc) m_q.push_back(ex_beat());
      m_rdy = (m_q.size() < 2);
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #23;
    model_reset();
    n_checks++;
    if (mem_if.valid !== 1'b0 || ex_if.ready !== 1'b1 || stall_cycles !== 8'd0 ||
        mem_beat() !== 24'h0 || fwd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: valid=%b ready=%b stall=%0d beat=%h fwd=%b, need 0 1 0 000000 0",
               mem_if.valid, ex_if.ready, stall_cycles, mem_beat(), fwd_valid);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_streaming();
    mem_if.ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h11 + i), 8'(8'h22 + i), 4'(i), 4'b0100);
      tick();
      n_checks++;
      if (mem_if.valid !== 1'b1 || mem_if.data_top !== 8'(8'h11 + i) ||
          mem_if.data_bot !== 8'(8'h22 + i) || mem_if.rd !== 4'(i) || ex_if.ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream[%0d]: valid=%b top=%h bot=%h rd=%h rdy=%b, need 1 %h %h %h 1",
                 i, mem_if.valid, mem_if.data_top, mem_if.data_bot, mem_if.rd, ex_if.ready,
                 8'(8'h11 + i), 8'(8'h22 + i), 4'(i));
      end
    end
    ex_if.valid = 1'b0;
    tick();
    n_checks++;
    if (mem_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drain: valid=%b need 0", mem_if.valid);
    end
  endtask

  task automatic test_back_pressure();
    logic [23:0] exp [3];
    exp[0] = 24'h41_A0_A1; exp[1] = 24'h82_B0_B1; exp[2] = 24'h13_C0_C1;
    out_q.delete();
    mem_if.ready = 1'b0;
    drive(1'b1, exp[0][15:8], exp[0][7:0], exp[0][19:16], exp[0][23:20]); tick();
    drive(1'b1, exp[1][15:8], exp[1][7:0], exp[1][19:16], exp[1][23:20]); tick();
    n_checks++;
    if (ex_if.ready !== 1'b0 || mem_beat() !== exp[0]) begin
      n_fail++;
      $display("FAIL bp_full: rdy=%b head=%h, need 0 %h", ex_if.ready, mem_beat(), exp[0]);
    end
    drive(1'b1, exp[2][15:8], exp[2][7:0], exp[2][19:16], exp[2][23:20]);
    repeat (3) tick();
    n_checks++;
    if (ex_if.ready !== 1'b0 || mem_if.valid !== 1'b1 || mem_beat() !== exp[0]) begin
      n_fail++;
      $display("FAIL bp_hold: rdy=%b valid=%b head=%h, need 0 1 %h",
               ex_if.ready, mem_if.valid, mem_beat(), exp[0]);
    end
    mem_if.ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (last_acc) ex_if.valid = 1'b0;
    end
    n_checks++;
    if (out_q.size() !== 3) begin
      n_fail++;
      $display("FAIL bp_count: popped %0d beats, need 3", out_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (out_q[k] !== exp[k]) begin
          n_fail++;
          $display("FAIL bp_order[%0d]: got %h need %h", k, out_q[k], exp[k]);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    mem_if.ready = 1'b0;
    drive(1'b1, 8'h5A, 8'h5B, 4'h3, 4'b0100); tick();
    drive(1'b1, 8'h6A, 8'h6B, 4'h7, 4'b1100);
    mem_if.ready = 1'b1;
    tick();
    n_checks++;
    if (mem_if.valid !== 1'b1 || mem_beat() !== 24'hC7_6A_6B || ex_if.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL simul: valid=%b head=%h rdy=%b, need 1 c76a6b 1",
               mem_if.valid, mem_beat(), ex_if.ready);
    end
    ex_if.valid = 1'b0;
    tick();
    n_checks++;
    if (mem_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_one_state: valid=%b after single pop, need 0", mem_if.valid);
    end
  endtask

  task automatic test_flush();
    mem_if.ready = 1'b0;
    drive(1'b1, 8'h71, 8'h72, 4'h1, 4'b0100); tick();
    drive(1'b1, 8'h81, 8'h82, 4'h2, 4'b0100); tick();
    drive(1'b1, 8'h91, 8'h92, 4'h3, 4'b0100);
    flush = 1'b1;
    mem_if.ready = 1'b1;
    tick();
    n_checks++;
    if (mem_if.valid !== 1'b0 || ex_if.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush: valid=%b rdy=%b, need 0 1", mem_if.valid, ex_if.ready);
    end
    flush = 1'b0;
    ex_if.valid = 1'b0;
    tick();
    n_checks++;
    if (mem_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drop: valid=%b need 0 (incoming beat must not be captured)", mem_if.valid);
    end
  endtask

  task automatic test_reset_mid_full();
    mem_if.ready = 1'b0;
    drive(1'b1, 8'h33, 8'h44, 4'h5, 4'b0100); tick();
    drive(1'b1, 8'h55, 8'h66, 4'h6, 4'b0100); tick();
    ex_if.valid = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (mem_if.valid !== 1'b0 || ex_if.ready !== 1'b1 || stall_cycles !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid_full: valid=%b rdy=%b stall=%0d, need 0 1 0",
               mem_if.valid, ex_if.ready, stall_cycles);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_counter();
    mem_if.ready = 1'b0;
    drive(1'b1, 8'hDE, 8'hAD, 4'h9, 4'b0100); tick();
    ex_if.valid = 1'b0;
    repeat (299) tick();
    n_checks++;
    if (stall_cycles !== 8'd255 || fwd_valid !== 1'b1 || fwd_rd !== 4'h9 || fwd_data !== 16'hDEAD) begin
      n_fail++;
      $display("FAIL counter_sat: stall=%0d fwd=%b rd=%h data=%h, need 255 1 9 dead",
               stall_cycles, fwd_valid, fwd_rd, fwd_data);
    end
    mem_if.ready = 1'b1; tick();
    mem_if.ready = 1'b0;
    drive(1'b1, 8'hBE, 8'hEF, 4'h4, 4'b1001); tick();
    ex_if.valid = 1'b0;
    tick();
    n_checks++;
    if (mem_if.valid !== 1'b1 || fwd_valid !== 1'b0 || stall_cycles !== 8'd255) begin
      n_fail++;
      $display("FAIL counter_fwd: valid=%b fwd=%b stall=%0d, need 1 0 255",
               mem_if.valid, fwd_valid, stall_cycles);
    end
    mem_if.ready = 1'b1; tick();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 600; c++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 4'($urandom), 4'($urandom));
      mem_if.ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 40) == 0);
      tick();
      n_checks++;
      if (mem_if.valid !== (m_q.size() > 0) || ex_if.ready !== m_rdy || stall_cycles !== 8'(m_cnt)) begin
        n_fail++; bad++;
        if (bad < 10)
          $display("FAIL rand_ctl[%0d]: valid=%b rdy=%b stall=%0d, need %b %b %0d",
                   c, mem_if.valid, ex_if.ready, stall_cycles, (m_q.size() > 0), m_rdy, m_cnt);
      end else if (m_q.size() > 0) begin
        n_checks++;
        if (mem_beat() !== m_q[0] || fwd_valid !== m_q[0][22] || fwd_data !== m_q[0][15:0]) begin
          n_fail++; bad++;
          if (bad < 10)
            $display("FAIL rand_head[%0d]: head=%h fwd=%b data=%h, need %h %b %h",
                     c, mem_beat(), fwd_valid, fwd_data, m_q[0], m_q[0][22], m_q[0][15:0]);
        end
      end
    end
    flush = 1'b0;
    ex_if.valid = 1'b0;
  endtask

  initial begin
    flush = 1'b0;
    mem_if.ready = 1'b0;
    drive(1'b0, 8'h0, 8'h0, 4'h0, 4'h0);
    last_acc = 1'b0;
    model_reset();
    test_reset();
    test_streaming();
    test_back_pressure();
    test_simultaneous();
    test_flush();
    test_reset_mid_full();
    test_counter();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
